// File: rtl/snap_vacc_ctrl_seq.sv
// Snapshot capture sequencer: arms on a rising edge of the software arm bit,
// optionally waits for an external trigger, then writes a fixed-length burst
// of accumulator samples into the snapshot BRAM and reports status.
module snap_vacc_ctrl_seq #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       ctrl_word,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              din_trig,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_data,
   output logic              bram_we,
   output logic [31:0]       status
);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   // wcount value at which the final word of a capture is being written
   localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

   state_t            state, state_nxt;
   logic [ADDR_W:0]   wcount, wcount_nxt;
   logic              arm_d;
   logic              arm_blk;   // set by reset, cleared once arm is seen low
   logic              arm_edge;
   logic              accept;
   logic [31:0]       status_nxt;
   logic              ctrl_unused;

   wire trig_mode = ctrl_word[1];
   wire we_mode   = ctrl_word[2];
   wire abort     = ctrl_word[3];

   assign ctrl_unused = ^ctrl_word[31:4];

   // An arm bit held high through reset must not look like a fresh edge,
   // so edges are suppressed until arm has been observed low once.
   assign arm_edge = ctrl_word[0] & ~arm_d & ~arm_blk;

   // Next-state, write acceptance and word-count update
   always_comb begin
      state_nxt  = state;
      wcount_nxt = wcount;
      accept     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (state == DONE && abort) begin
               state_nxt = IDLE;
            end else if (arm_edge && !abort) begin
               wcount_nxt = '0;
               state_nxt  = trig_mode ? ARMED : CAPTURE;
            end
         end
         ARMED: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (din_valid && din_trig) begin
               // the trigger sample itself becomes word 0
               accept    = 1'b1;
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (we_mode || din_valid) begin
               accept = 1'b1;
               if (wcount == LAST) state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (accept) wcount_nxt = wcount + 1'b1;
   end

   // Status is built from next-state values so done rises with the last write
   always_comb begin
      status_nxt     = 32'(wcount_nxt);
      status_nxt[31] = (state_nxt == DONE);
      status_nxt[30] = (state_nxt == ARMED) || (state_nxt == CAPTURE);
      status_nxt[29] = (state_nxt == ARMED);
   end

   // State, counters and the single-stage BRAM write pipeline
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state     <= IDLE;
         wcount    <= '0;
         arm_d     <= 1'b0;
         arm_blk   <= 1'b1;
         bram_we   <= 1'b0;
         bram_addr <= '0;
         bram_data <= '0;
         status    <= '0;
      end else begin
         state   <= state_nxt;
         wcount  <= wcount_nxt;
         arm_d   <= ctrl_word[0];
         arm_blk <= arm_blk & ctrl_word[0];
         bram_we <= accept;
         if (accept) begin
            bram_addr <= wcount[ADDR_W-1:0];
            bram_data <= din;
         end
         status  <= status_nxt;
      end
   end

endmodule

// File: tb/tb_snap_vacc_ctrl_seq.sv
// Directed bench for the snapshot capture sequencer (16-word captures).
module tb_snap_vacc_ctrl_seq;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;

   logic              user_clk = 1'b0;
   logic              user_rst = 1'b1;
   logic [31:0]       ctrl_word = '0;
   logic [DATA_W-1:0] din = '0;
   logic              din_valid = 1'b0;
   logic              din_trig = 1'b0;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_data;
   logic              bram_we;
   logic [31:0]       status;

   int total = 0;
   int bad   = 0;

   snap_vacc_ctrl_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .user_clk (user_clk),
      .user_rst (user_rst),
      .ctrl_word(ctrl_word),
      .din      (din),
      .din_valid(din_valid),
      .din_trig (din_trig),
      .bram_addr(bram_addr),
      .bram_data(bram_data),
      .bram_we  (bram_we),
      .status   (status)
   );

   always #5 user_clk = ~user_clk;

   // advance one edge; outputs are sampled 1 ns after it
   task automatic step();
      @(posedge user_clk);
      #1;
   endtask

   task automatic go_idle();
      ctrl_word = 32'h8; din_valid = 0; din_trig = 0;
      step();
      ctrl_word = 32'h0;
      step();
   endtask

   task automatic test_reset();
      user_rst = 1; ctrl_word = 0;
      step(); step();
      total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL rst_we got %b want 0", bram_we); end
      total++; if (bram_addr !== '0) begin bad++; $display("FAIL rst_addr got %h want 0", bram_addr); end
      total++; if (bram_data !== '0) begin bad++; $display("FAIL rst_data got %h want 0", bram_data); end
      total++; if (status !== 32'h0) begin bad++; $display("FAIL rst_status got %h want 0", status); end
      user_rst = 0;
      step();
   endtask

   task automatic test_immediate();
      go_idle();
      ctrl_word = 32'h5; din = 0;
      step();
      total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL imm_first_we got %b want 0", bram_we); end
      total++; if (status !== 32'h4000_0000) begin bad++; $display("FAIL imm_busy got %h want 40000000", status); end
      for (int i = 0; i < 16; i++) begin
         din = i;
         step();
         total++;
         if (bram_we !== 1'b1 || bram_addr !== 4'(i) || bram_data !== 32'(i)) begin
            bad++; $display("FAIL imm_wr[%0d] got we=%b a=%h d=%h want we=1 a=%h d=%h", i, bram_we, bram_addr, bram_data, i, i);
         end
      end
      total++; if (status !== 32'h8000_0010) begin bad++; $display("FAIL imm_done got %h want 80000010", status); end
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL imm_after_we[%0d] got %b want 0", i, bram_we); end
      end
      total++; if (status !== 32'h8000_0010) begin bad++; $display("FAIL imm_hold got %h want 80000010", status); end
   endtask

   task automatic test_ext_trigger();
      go_idle();
      ctrl_word = 32'h2;
      step();
      ctrl_word = 32'h3;
      step();
      total++; if (status !== 32'h6000_0000) begin bad++; $display("FAIL ext_armed got %h want 60000000", status); end
      din_valid = 1; din = 32'h55; din_trig = 0;
      step();
      total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL ext_pretrig_we got %b want 0", bram_we); end
      din_valid = 0; din_trig = 1;  // trigger without valid is ignored
      step();
      total++; if (status !== 32'h6000_0000) begin bad++; $display("FAIL ext_still_armed got %h want 60000000", status); end
      din_valid = 1; din_trig = 1; din = 32'h100;
      step();
      total++;
      if (bram_we !== 1'b1 || bram_addr !== 4'h0 || bram_data !== 32'h100) begin
         bad++; $display("FAIL ext_word0 got we=%b a=%h d=%h want we=1 a=0 d=100", bram_we, bram_addr, bram_data);
      end
      total++; if (status !== 32'h4000_0001) begin bad++; $display("FAIL ext_cap_status got %h want 40000001", status); end
      din_trig = 0;
      for (int k = 1; k < 16; k++) begin
         din_valid = 0;
         step();
         total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL ext_gap_we[%0d] got %b want 0", k, bram_we); end
         din_valid = 1; din = 32'h100 + k;
         step();
         total++;
         if (bram_we !== 1'b1 || bram_addr !== 4'(k) || bram_data !== 32'h100 + k) begin
            bad++; $display("FAIL ext_wr[%0d] got we=%b a=%h d=%h want we=1 a=%h d=%h", k, bram_we, bram_addr, bram_data, k, 32'h100 + k);
         end
      end
      total++; if (status !== 32'h8000_0010) begin bad++; $display("FAIL ext_done got %h want 80000010", status); end
      din_valid = 0;
   endtask

   task automatic test_valid_gating();
      go_idle();
      ctrl_word = 32'h1; din_valid = 1; din = 32'h1ff;
      step();
      for (int i = 0; i < 16; i++) begin
         if (i == 6) begin
            din_valid = 0;
            for (int g = 0; g < 5; g++) begin
               step();
               total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL gate_gap_we[%0d] got %b want 0", g, bram_we); end
            end
            din_valid = 1;
         end
         din = 32'h200 + i;
         step();
         total++;
         if (bram_we !== 1'b1 || bram_addr !== 4'(i) || bram_data !== 32'h200 + i) begin
            bad++; $display("FAIL gate_wr[%0d] got we=%b a=%h d=%h want we=1 a=%h d=%h", i, bram_we, bram_addr, bram_data, i, 32'h200 + i);
         end
      end
      total++; if (status !== 32'h8000_0010) begin bad++; $display("FAIL gate_done got %h want 80000010", status); end
      din_valid = 0;
   endtask

   task automatic test_abort();
      go_idle();
      ctrl_word = 32'h5;
      step();
      for (int i = 0; i < 7; i++) begin
         din = 32'h300 + i;
         step();
         total++;
         if (bram_we !== 1'b1 || bram_addr !== 4'(i)) begin
            bad++; $display("FAIL abort_wr[%0d] got we=%b a=%h want we=1 a=%h", i, bram_we, bram_addr, i);
         end
      end
      ctrl_word = 32'hD;
      step();
      total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL abort_we got %b want 0", bram_we); end
      total++; if (status !== 32'h0000_0007) begin bad++; $display("FAIL abort_status got %h want 00000007", status); end
      step();
      total++; if (bram_we !== 1'b0 || status !== 32'h7) begin bad++; $display("FAIL abort_hold got we=%b st=%h want we=0 st=7", bram_we, status); end
      ctrl_word = 32'h4;
      step();
      ctrl_word = 32'h5; din = 32'h400;
      step();
      total++; if (status !== 32'h4000_0000) begin bad++; $display("FAIL abort_rearm got %h want 40000000", status); end
      step();
      total++;
      if (bram_we !== 1'b1 || bram_addr !== 4'h0 || bram_data !== 32'h400 || status !== 32'h4000_0001) begin
         bad++; $display("FAIL abort_restart got we=%b a=%h d=%h st=%h want we=1 a=0 d=400 st=40000001", bram_we, bram_addr, bram_data, status);
      end
   endtask

   task automatic test_rearm();
      go_idle();
      ctrl_word = 32'h5;
      step();
      for (int i = 0; i < 16; i++) begin
         if (i == 5) ctrl_word = 32'h4;
         if (i == 6) ctrl_word = 32'h5;  // edge while capturing is ignored
         din = 32'h500 + i;
         step();
         total++;
         if (bram_we !== 1'b1 || bram_addr !== 4'(i) || bram_data !== 32'h500 + i) begin
            bad++; $display("FAIL rearm_wr[%0d] got we=%b a=%h d=%h want we=1 a=%h d=%h", i, bram_we, bram_addr, bram_data, i, 32'h500 + i);
         end
      end
      step();
      total++; if (bram_we !== 1'b0 || status !== 32'h8000_0010) begin bad++; $display("FAIL rearm_done got we=%b st=%h want we=0 st=80000010", bram_we, status); end
      ctrl_word = 32'h4;
      step();
      total++; if (status !== 32'h8000_0010) begin bad++; $display("FAIL rearm_low got %h want 80000010", status); end
      ctrl_word = 32'h5; din = 32'h600;
      step();
      total++; if (status !== 32'h4000_0000 || bram_we !== 1'b0) begin bad++; $display("FAIL rearm_restart got we=%b st=%h want we=0 st=40000000", bram_we, status); end
      step();
      total++;
      if (bram_we !== 1'b1 || bram_addr !== 4'h0 || bram_data !== 32'h600) begin
         bad++; $display("FAIL rearm_word0 got we=%b a=%h d=%h want we=1 a=0 d=600", bram_we, bram_addr, bram_data);
      end
   endtask

   task automatic test_reset_mid();
      go_idle();
      ctrl_word = 32'h5;
      step();
      for (int i = 0; i < 9; i++) begin
         din = 32'h700 + i;
         step();
      end
      total++; if (bram_we !== 1'b1 || bram_addr !== 4'h8) begin bad++; $display("FAIL rstmid_pre got we=%b a=%h want we=1 a=8", bram_we, bram_addr); end
      user_rst = 1;
      step();
      total++;
      if (bram_we !== 1'b0 || status !== 32'h0 || bram_addr !== '0 || bram_data !== '0) begin
         bad++; $display("FAIL rstmid_clear got we=%b st=%h a=%h d=%h want all 0", bram_we, status, bram_addr, bram_data);
      end
      user_rst = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (bram_we !== 1'b0 || status !== 32'h0) begin bad++; $display("FAIL rstmid_noarm[%0d] got we=%b st=%h want we=0 st=0", i, bram_we, status); end
      end
      ctrl_word = 32'h4;
      step();
      ctrl_word = 32'h5;
      step();
      total++; if (status !== 32'h4000_0000) begin bad++; $display("FAIL rstmid_toggle got %h want 40000000", status); end
   endtask

   initial begin
      test_reset();
      test_immediate();
      test_ext_trigger();
      test_valid_gating();
      test_abort();
      test_rearm();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
